// File: rtl/multi_reg_file.sv
// Multi-register file. Every register selected by RegSel gets the same FunSel
// operation on each rising Clock edge. Two independent combinational read ports.
// Each register has a sticky Wrap flag that records increment/decrement boundary events.
// Optional feature macro: MRF_SATURATE_EN. When it is defined, increment and decrement
// saturate at the boundaries instead of wrapping.
// Reset is synchronous and active-low.
module multi_reg_file #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int SELW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [1:0]       FunSel,
  input  logic [DEPTH-1:0] RegSel,
  input  logic [WIDTH-1:0] I,
  input  logic [SELW-1:0]  OutASel,
  input  logic [SELW-1:0]  OutBSel,
  input  logic             FlagClr,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic [DEPTH-1:0] Wrap
);

  localparam logic [1:0] FnClear = 2'b00;
  localparam logic [1:0] FnLoad  = 2'b01;
  localparam logic [1:0] FnDec   = 2'b10;
  localparam logic [1:0] FnInc   = 2'b11;

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] r_wrap;

  logic [WIDTH-1:0] w_next [DEPTH];
  logic [DEPTH-1:0] w_bound;

  // Candidate next value and boundary event per register
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_next[k]  = r_regs[k];
      w_bound[k] = 1'b0;
      case (FunSel)
        FnClear: w_next[k] = '0;
        FnLoad:  w_next[k] = I;
        FnDec: begin
          // Only a selected register can raise a boundary event
          w_bound[k] = RegSel[k] && (r_regs[k] == '0);
`ifdef MRF_SATURATE_EN
          w_next[k]  = (r_regs[k] == '0) ? r_regs[k] : r_regs[k] - 1'b1;
`else
          w_next[k]  = r_regs[k] - 1'b1;
`endif
        end
        FnInc: begin
          w_bound[k] = RegSel[k] && (r_regs[k] == '1);
`ifdef MRF_SATURATE_EN
          w_next[k]  = (r_regs[k] == '1) ? r_regs[k] : r_regs[k] + 1'b1;
`else
          w_next[k]  = r_regs[k] + 1'b1;
`endif
        end
        default: w_next[k] = r_regs[k];
      endcase
    end
  end

  // Register and sticky-flag state; a new boundary event beats FlagClr
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_regs[k] <= '0;
      end
      r_wrap <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (RegSel[k]) begin
          r_regs[k] <= w_next[k];
        end
      end
      r_wrap <= (FlagClr ? '0 : r_wrap) | w_bound;
    end
  end

  // Read ports from current state; an index with no register behind it reads 0
  always_comb begin
    OutA = '0;
    OutB = '0;
    if (int'(OutASel) < DEPTH) begin
      OutA = r_regs[OutASel];
    end
    if (int'(OutBSel) < DEPTH) begin
      OutB = r_regs[OutBSel];
    end
  end

  assign Wrap = r_wrap;

endmodule

// File: tb/tb_multi_reg_file.sv
// Directed self-checking bench for multi_reg_file. It uses a WIDTH=8, DEPTH=4 instance
// for the main behaviour. A second DEPTH=3 instance checks reads of a select that has
// no register behind it.
module tb_multi_reg_file;

  logic       Clock;
  logic       Reset;
  logic [1:0] FunSel;
  logic [3:0] RegSel;
  logic [7:0] I;
  logic [1:0] OutASel;
  logic [1:0] OutBSel;
  logic       FlagClr;
  logic [7:0] OutA;
  logic [7:0] OutB;
  logic [3:0] Wrap;

  logic [1:0] OutASel3;
  logic [1:0] OutBSel3;
  logic [7:0] OutA3;
  logic [7:0] OutB3;
  logic [2:0] Wrap3;

  int checks = 0;
  int errors = 0;

  multi_reg_file #(.WIDTH(8), .DEPTH(4)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .FunSel  (FunSel),
    .RegSel  (RegSel),
    .I       (I),
    .OutASel (OutASel),
    .OutBSel (OutBSel),
    .FlagClr (FlagClr),
    .OutA    (OutA),
    .OutB    (OutB),
    .Wrap    (Wrap)
  );

  multi_reg_file #(.WIDTH(8), .DEPTH(3)) dut3 (
    .Clock   (Clock),
    .Reset   (Reset),
    .FunSel  (FunSel),
    .RegSel  (RegSel[2:0]),
    .I       (I),
    .OutASel (OutASel3),
    .OutBSel (OutBSel3),
    .FlagClr (FlagClr),
    .OutA    (OutA3),
    .OutB    (OutB3),
    .Wrap    (Wrap3)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp_r [4];
    Reset = 1'b0; FunSel = 2'b01; RegSel = 4'b1111; I = 8'hFF; FlagClr = 1'b0;
    OutASel = '0; OutBSel = '0; OutASel3 = '0; OutBSel3 = '0;
    tick();
    tick();
    Reset = 1'b1; RegSel = 4'b0000;
    exp_r = '{8'h00, 8'h00, 8'h00, 8'h00};
    for (int k = 0; k < 4; k++) begin
      OutASel = 2'(k); OutBSel = 2'(3 - k); #1;
      checks++;
      if (OutA !== exp_r[k]) begin
        errors++; $display("FAIL reset_outa[%0d]: got %h expected %h", k, OutA, exp_r[k]);
      end
      checks++;
      if (OutB !== exp_r[3-k]) begin
        errors++; $display("FAIL reset_outb[%0d]: got %h expected %h", 3 - k, OutB, exp_r[3-k]);
      end
    end
    checks++;
    if (Wrap !== 4'b0000) begin
      errors++; $display("FAIL reset_wrap: got %b expected 0000", Wrap);
    end
  endtask

  task automatic test_load_inc();
    logic [7:0] exp_r [4];
    RegSel = 4'b0101; FunSel = 2'b01; I = 8'hAA;
    tick();
    exp_r = '{8'hAA, 8'h00, 8'hAA, 8'h00};
    for (int k = 0; k < 4; k++) begin
      OutASel = 2'(k); #1;
      checks++;
      if (OutA !== exp_r[k]) begin
        errors++; $display("FAIL load_r%0d: got %h expected %h", k, OutA, exp_r[k]);
      end
    end
    FunSel = 2'b11;
    tick();
    exp_r = '{8'hAB, 8'h00, 8'hAB, 8'h00};
    for (int k = 0; k < 4; k++) begin
      OutBSel = 2'(k); #1;
      checks++;
      if (OutB !== exp_r[k]) begin
        errors++; $display("FAIL inc_r%0d: got %h expected %h", k, OutB, exp_r[k]);
      end
    end
    checks++;
    if (Wrap !== 4'b0000) begin
      errors++; $display("FAIL inc_wrap: got %b expected 0000", Wrap);
    end
  endtask

  task automatic test_inc_wrap();
    logic [7:0] exp_r1;
    RegSel = 4'b0010; FunSel = 2'b01; I = 8'hFF;
    tick();
    FunSel = 2'b11;
    tick();
`ifdef MRF_SATURATE_EN
    exp_r1 = 8'hFF;
`else
    exp_r1 = 8'h00;
`endif
    OutASel = 2'd1; OutBSel = 2'd0; #1;
    checks++;
    if (OutA !== exp_r1) begin
      errors++; $display("FAIL incwrap_r1: got %h expected %h", OutA, exp_r1);
    end
    checks++;
    if (OutB !== 8'hAB) begin
      errors++; $display("FAIL incwrap_hold_r0: got %h expected ab", OutB);
    end
    checks++;
    if (Wrap !== 4'b0010) begin
      errors++; $display("FAIL incwrap_flag: got %b expected 0010", Wrap);
    end
  endtask

  task automatic test_dec_flagclr();
    logic [7:0] exp_r3;
`ifdef MRF_SATURATE_EN
    exp_r3 = 8'h00;
`else
    exp_r3 = 8'hFF;
`endif
    // Clearing never sets a flag
    RegSel = 4'b1000; FunSel = 2'b00;
    tick();
    checks++;
    if (Wrap !== 4'b0010) begin
      errors++; $display("FAIL clear_noflag: got %b expected 0010", Wrap);
    end
    FunSel = 2'b10;
    tick();
    OutASel = 2'd3; #1;
    checks++;
    if (OutA !== exp_r3) begin
      errors++; $display("FAIL dec_r3: got %h expected %h", OutA, exp_r3);
    end
    checks++;
    if (Wrap !== 4'b1010) begin
      errors++; $display("FAIL dec_flag: got %b expected 1010", Wrap);
    end
    // Reload zero; loading never sets a flag and the old flags stay
    FunSel = 2'b01; I = 8'h00;
    tick();
    checks++;
    if (Wrap !== 4'b1010) begin
      errors++; $display("FAIL load_noflag: got %b expected 1010", Wrap);
    end
    // Decrement at zero with FlagClr: bit 3 is set again, bit 1 is cleared
    FunSel = 2'b10; FlagClr = 1'b1;
    tick();
    #1;
    checks++;
    if (OutA !== exp_r3) begin
      errors++; $display("FAIL decclr_r3: got %h expected %h", OutA, exp_r3);
    end
    checks++;
    if (Wrap !== 4'b1000) begin
      errors++; $display("FAIL decclr_flag: got %b expected 1000", Wrap);
    end
    RegSel = 4'b0000;
    tick();
    checks++;
    if (Wrap !== 4'b0000) begin
      errors++; $display("FAIL flagclr: got %b expected 0000", Wrap);
    end
    FlagClr = 1'b0;
  endtask

  task automatic test_reset_mid();
    RegSel = 4'b1111; FunSel = 2'b11;
    tick();
    Reset = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      OutASel = 2'(k); #1;
      checks++;
      if (OutA !== 8'h00) begin
        errors++; $display("FAIL midreset_r%0d: got %h expected 00", k, OutA);
      end
    end
    checks++;
    if (Wrap !== 4'b0000) begin
      errors++; $display("FAIL midreset_wrap: got %b expected 0000", Wrap);
    end
    Reset = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      OutBSel = 2'(k); #1;
      checks++;
      if (OutB !== 8'h01) begin
        errors++; $display("FAIL resume_r%0d: got %h expected 01", k, OutB);
      end
    end
  endtask

  task automatic test_read_timing();
    RegSel = 4'b0100; FunSel = 2'b01; I = 8'h5A; OutASel = 2'd2;
    #1;
    checks++;
    if (OutA !== 8'h01) begin
      errors++; $display("FAIL read_before_edge: got %h expected 01", OutA);
    end
    tick();
    checks++;
    if (OutA !== 8'h5A) begin
      errors++; $display("FAIL read_after_edge: got %h expected 5a", OutA);
    end
    RegSel = 4'b0000;
  endtask

  task automatic test_out_of_range();
    RegSel = 4'b0111; FunSel = 2'b01; I = 8'h77;
    tick();
    RegSel = 4'b0000;
    OutASel3 = 2'd2; OutBSel3 = 2'd3; #1;
    checks++;
    if (OutA3 !== 8'h77) begin
      errors++; $display("FAIL d3_read_r2: got %h expected 77", OutA3);
    end
    checks++;
    if (OutB3 !== 8'h00) begin
      errors++; $display("FAIL d3_read_idx3: got %h expected 00", OutB3);
    end
    OutBSel3 = 2'd0; #1;
    checks++;
    if (OutB3 !== 8'h77) begin
      errors++; $display("FAIL d3_read_r0: got %h expected 77", OutB3);
    end
  endtask

  initial begin
    test_reset();
    test_load_inc();
    test_inc_wrap();
    test_dec_flagclr();
    test_reset_mid();
    test_read_timing();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_reg_file.md
MULTI_REG_FILE -- requirements
Module: multi_reg_file

Interface
REQ-001 Parameter WIDTH, default 8: bit width of every register and data port, legal range 2..32.
REQ-002 Parameter DEPTH, default 4: number of registers, legal range 2..16.
REQ-003 Derived SELW = max(1, clog2(DEPTH)): read-select width, not overridable.
REQ-004 Clock  input  1: rising-edge clock for all state.
REQ-005 Reset  input  1: synchronous, active-low reset.
REQ-006 FunSel  input  2: operation applied to every enabled register.
REQ-007 RegSel  input  DEPTH: per-register write enable, active-high, bit k enables register k.
REQ-008 I  input  WIDTH: load data.
REQ-009 OutASel  input  SELW: register index driven on OutA.
REQ-010 OutBSel  input  SELW: register index driven on OutB.
REQ-011 FlagClr  input  1: clears all sticky Wrap bits.
REQ-012 OutA  output  WIDTH: contents of register OutASel.
REQ-013 OutB  output  WIDTH: contents of register OutBSel.
REQ-014 Wrap  output  DEPTH: per-register sticky boundary flag.

Function
REQ-015 FunSel encoding SHALL be 00 clear to 0, 01 load I, 10 Q-1, 11 Q+1.
REQ-016 Each register with RegSel[k]=1 SHALL update on the rising Clock edge, with a one-cycle write latency.
REQ-017 Registers with RegSel[k]=0 SHALL hold their value.
REQ-018 Several RegSel bits set together SHALL apply the same FunSel independently to each selected register in the same cycle.
REQ-019 OutA and OutB SHALL be combinational from current register state, with no forwarding of the write in progress.
REQ-020 A read select >= DEPTH SHALL drive 0 on that output.
REQ-021 Increment at all-ones, or decrement at 0, on register k SHALL set Wrap[k] on that edge.
REQ-022 Wrap[k] SHALL stay set until FlagClr is sampled high.
REQ-023 FlagClr and a new boundary event on register k in the same cycle SHALL leave Wrap[k]=1 (set wins).
REQ-024 Clear and load SHALL never set Wrap.
REQ-025 Arithmetic SHALL be unsigned modulo 2^WIDTH unless REQ-029 applies.

Reset
REQ-026 Reset=0 at a rising edge SHALL force all registers and all Wrap bits to 0, regardless of FunSel, RegSel or FlagClr.
REQ-027 After a reset edge, OutA and OutB SHALL read 0 for every in-range select.
REQ-028 Reset asserted mid-sequence SHALL discard the pending operation for that cycle, and operation SHALL resume on the first edge with Reset=1.

Configuration
REQ-029 With macro MRF_SATURATE_EN defined, increment at all-ones SHALL hold all-ones and decrement at 0 SHALL hold 0, and Wrap SHALL still be set per REQ-021.
REQ-030 With MRF_SATURATE_EN undefined, increment and decrement SHALL wrap modulo 2^WIDTH per REQ-025.

Verification (WIDTH=8, DEPTH=4)
REQ-031 Reset=0 for 2 cycles, then Reset=1 -> OutA=OutB=0 for selects 0..3, and Wrap=0000.
REQ-032 RegSel=0101, FunSel=01, I=0xAA, one edge -> R0=R2=0xAA and R1=R3=0; then FunSel=11 on one edge -> R0=R2=0xAB.
REQ-033 R1=0xFF, RegSel=0010, FunSel=11 -> without macro R1=0x00 and Wrap=0010; with macro R1=0xFF and Wrap=0010.
REQ-034 R3=0x00 and Wrap[3]=1, then decrement with FlagClr=1 in the same cycle -> Wrap[3]=1, R3=0xFF (no macro); next cycle FlagClr=1 with RegSel=0 -> Wrap=0000.
REQ-035 RegSel=1111, FunSel=11 held 3 cycles, with Reset=0 on cycle 2 -> all registers 0 after cycle 2 and all 1 after cycle 3.
REQ-036 Write 0x5A to R2 while OutASel=2 -> OutA shows the old value until the edge and 0x5A after it; OutASel=2 with DEPTH=3 and SELW=2 reading index 3 -> OutB=0.
